// File: rtl/xdrop_score_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// xdrop_score_accumulator_pkg
// Shared definitions for the ungapped-extension datapath.
//   - 2-bit score encodings emitted by the score selector (signed two's
//     complement: match +1, mismatch -1, gap -2, zero 0).
//   - State encoding for the X-drop score accumulator FSM.
// ---------------------------------------------------------------------------
package xdrop_score_accumulator_pkg;

  localparam logic [1:0] SC_ZERO     = 2'b00;
  localparam logic [1:0] SC_MATCH    = 2'b01;
  localparam logic [1:0] SC_GAP      = 2'b10;
  localparam logic [1:0] SC_MISMATCH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXTEND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/xdrop_score_accumulator_score_sat_add.sv
// ---------------------------------------------------------------------------
// score_sat_add
// Combinational signed saturating adder: sum = sat(acc + sext(score)).
// Ports:
//   acc   in  SCORE_W  current signed accumulator value
//   score in  2        selector score code (see package encodings)
//   sum   out SCORE_W  acc plus decoded score, clamped to the signed range
// ---------------------------------------------------------------------------
module score_sat_add
  import xdrop_score_accumulator_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic [SCORE_W-1:0] acc,
  input  logic [1:0]         score,
  output logic [SCORE_W-1:0] sum
);

  logic [SCORE_W:0] incr;
  logic [SCORE_W:0] wide;

  // Decode the score into a sign-extended increment and add one bit wider
  // than the accumulator; the top two bits disagreeing means the true result
  // left the signed range, and the extra top bit tells which way it went.
  always_comb begin
    incr = '0;
    case (score)
      SC_MATCH:    incr = (SCORE_W+1)'(1);
      SC_MISMATCH: incr = '1;
      SC_GAP:      incr = {{(SCORE_W){1'b1}}, 1'b0};
      SC_ZERO:     incr = '0;
      default:     incr = '0;
    endcase
    wide = {acc[SCORE_W-1], acc} + incr;
    if (wide[SCORE_W] != wide[SCORE_W-1]) begin
      if (wide[SCORE_W]) begin
        sum = {1'b1, {(SCORE_W-1){1'b0}}};
      end else begin
        sum = {1'b0, {(SCORE_W-1){1'b1}}};
      end
    end else begin
      sum = wide[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/xdrop_score_accumulator.sv
// ---------------------------------------------------------------------------
// xdrop_score_accumulator
// Accumulates per-position selector scores, tracks the running maximum and
// where it was first reached, and terminates an extension on X-drop
// (max - current >= XDROP) or on the last beat. The result record is held
// for the hit-reporting stage behind a valid/ready handshake.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin an extension (IDLE only)
//   in_valid/in_ready beat handshake; in_score 2-bit score, in_last final beat
//   out_valid/out_ready result handshake
//   out_max_score     best accumulated score (signed, >= 0)
//   out_max_pos       1-based beat index of first max, 0 if max stayed 0
//   out_len           beats consumed
//   out_xdrop         1 = ended by X-drop, 0 = ended by in_last
// ---------------------------------------------------------------------------
module xdrop_score_accumulator
  import xdrop_score_accumulator_pkg::*;
#(
  parameter int SCORE_W = 16,
  parameter int POS_W   = 16,
  parameter int XDROP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [1:0]         in_score,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] out_max_score,
  output logic [POS_W-1:0]   out_max_pos,
  output logic [POS_W-1:0]   out_len,
  output logic               out_xdrop
);

  localparam logic signed [SCORE_W:0] XDROP_T = (SCORE_W+1)'(XDROP);

  state_t state_q, state_d;

  logic signed [SCORE_W-1:0] acc_q, max_q;
  logic [POS_W-1:0]          pos_q, max_pos_q;

  logic [SCORE_W-1:0]        sum;
  logic signed [SCORE_W-1:0] acc_n, max_n;
  logic [POS_W-1:0]          pos_n, max_pos_n;
  logic signed [SCORE_W:0]   drop;
  logic                      beat, xdrop_hit, term;

  logic [SCORE_W-1:0]        res_max_q;
  logic [POS_W-1:0]          res_pos_q, res_len_q;
  logic                      res_xdrop_q;

  score_sat_add #(.SCORE_W(SCORE_W)) u_add (
    .acc   (acc_q),
    .score (in_score),
    .sum   (sum)
  );

  // Per-beat datapath: next accumulator, saturating position, strict-greater
  // max update (ties keep the earlier position) and the X-drop test, which is
  // done one bit wider so max minus a very negative acc cannot overflow.
  always_comb begin
    beat      = (state_q == ST_EXTEND) && in_valid;
    acc_n     = sum;
    pos_n     = (pos_q == '1) ? pos_q : pos_q + POS_W'(1);
    max_n     = max_q;
    max_pos_n = max_pos_q;
    if (acc_n > max_q) begin
      max_n     = acc_n;
      max_pos_n = pos_n;
    end
    drop      = {max_n[SCORE_W-1], max_n} - {acc_n[SCORE_W-1], acc_n};
    xdrop_hit = (drop >= XDROP_T);
    term      = beat && (xdrop_hit || in_last);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs, which depend on state alone.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_EXTEND;
      end
      ST_EXTEND: begin
        in_ready = 1'b1;
        if (term) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Working registers and the held result record. A start in IDLE clears
  // everything; the result record is only written on the terminating beat,
  // so it stays stable through DONE and afterwards in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      max_q       <= '0;
      pos_q       <= '0;
      max_pos_q   <= '0;
      res_max_q   <= '0;
      res_pos_q   <= '0;
      res_len_q   <= '0;
      res_xdrop_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      acc_q       <= '0;
      max_q       <= '0;
      pos_q       <= '0;
      max_pos_q   <= '0;
      res_max_q   <= '0;
      res_pos_q   <= '0;
      res_len_q   <= '0;
      res_xdrop_q <= 1'b0;
    end else if (beat) begin
      acc_q     <= acc_n;
      max_q     <= max_n;
      pos_q     <= pos_n;
      max_pos_q <= max_pos_n;
      if (term) begin
        res_max_q   <= max_n;
        res_pos_q   <= max_pos_n;
        res_len_q   <= pos_n;
        res_xdrop_q <= xdrop_hit;
      end
    end
  end

  assign out_max_score = res_max_q;
  assign out_max_pos   = res_pos_q;
  assign out_len       = res_len_q;
  assign out_xdrop     = res_xdrop_q;

endmodule

// File: doc/xdrop_score_accumulator.md
Name: xdrop_score_accumulator

Overview:
- Downstream consumer of the score selector in the ungapped-extension datapath.
- Accumulates the per-position 2-bit scores the selector emits, one per beat, and tracks the running maximum and its position.
- Terminates the extension on BLAST X-drop (max minus current >= XDROP) or on the last beat.
- Presents a held result record to the hit-reporting stage through a valid/ready handshake.

Parameters:
- SCORE_W, 16, width of the signed accumulator and max score (two's complement).
- POS_W, 16, width of the position/length counters (unsigned).
- XDROP, 4, drop threshold; positive, must be < 2^(SCORE_W-1).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new extension; honoured only in IDLE.
- in_valid  in  1  in_score/in_last are valid this cycle.
- in_score  in  2  selector output, signed two's complement: match 01=+1, mismatch 11=-1, gap 10=-2, 00=0.
- in_last  in  1  this beat is the final position of the sequence window.
- in_ready  out  1  block accepts a beat this cycle.
- out_valid  out  1  result record valid.
- out_ready  in  1  consumer accepts the result.
- out_max_score  out  SCORE_W  best accumulated score (signed, >= 0).
- out_max_pos  out  POS_W  1-based beat index where the max was first reached; 0 if the max never exceeded 0.
- out_len  out  POS_W  number of beats consumed.
- out_xdrop  out  1  1 = terminated by X-drop; 0 = terminated by in_last.

Behaviour:
- States: IDLE, EXTEND, DONE. Reset puts the block in IDLE. On reset in_ready=0, out_valid=0, and all result outputs and internal registers are 0.
- IDLE: in_ready=0, out_valid=0. start=1 clears acc, max, pos and max_pos to 0; next state EXTEND.
- EXTEND: in_ready=1. Cycles with in_valid=0 change nothing. On in_valid=1, in order:
  - acc_n = sat(acc + sext(in_score)); saturate at the SCORE_W signed min/max.
  - pos_n = pos + 1, saturating at all-ones (no wrap).
  - If acc_n > max (strict, so ties keep the earlier position): max = acc_n, max_pos = pos_n.
  - If (new max) - acc_n >= XDROP: go to DONE with xdrop=1.
  - Else if in_last: go to DONE with xdrop=0.
  - If X-drop and in_last occur on the same beat: xdrop=1.
- Output latency: result registers update on the terminating beat's clock edge. out_valid=1 in the following cycle; in_ready drops in that same cycle.
- DONE: out_valid=1; in_ready=0. All out_* are held stable while out_ready=0. out_valid & out_ready moves to IDLE, and out_valid=0 the next cycle. start is ignored in EXTEND and DONE.
- Result outputs are registered and keep their last values in IDLE until the next start clears them.
- The difference max-acc_n is computed at SCORE_W+1 bits, so it cannot overflow.
- Reset asserted mid-EXTEND or mid-DONE: the block returns to IDLE with all state zeroed on that edge, and the pending result is discarded.
- Throughput: 1 beat/cycle in EXTEND. There is at least 1 idle cycle between extensions because start is only sampled in IDLE.

Decomposition:
- Shared package holds:
  - the score encoding constants (SC_MATCH=2'b01, SC_MISMATCH=2'b11, SC_GAP=2'b10, SC_ZERO=2'b00), shared with the selector and the score-table logic;
  - the state encoding (IDLE/EXTEND/DONE).
- One sub-module, score_sat_add: a combinational SCORE_W signed saturating adder of acc plus the sign-extended 2-bit score. This keeps the saturation logic independently testable.

Test Plan (XDROP=4):
- X-drop termination: start; five beats of +1, then four beats of -1 -> terminates on the 9th beat; out_max_score=5, out_max_pos=5, out_len=9, out_xdrop=1.
- Last-beat termination with tie: beats +1,+1,-1,+1 with in_last on the 4th -> out_max_score=2, out_max_pos=2 (tie at pos 4 not taken), out_len=4, out_xdrop=0.
- Gaps only: beats -2,-2 -> X-drop on beat 2; out_max_score=0, out_max_pos=0, out_len=2, out_xdrop=1. Same run with in_last on beat 2 -> out_xdrop=1.
- Bubbles and backpressure: in_valid toggling 1,0,0,1 leaves acc/pos unchanged on the bubble cycles. In DONE, hold out_ready=0 for 5 cycles with start=1 -> outputs constant, in_ready=0, no restart; out_ready=1 -> IDLE next cycle.
- Reset mid-extension: rst after 3 beats of +1 -> next cycle in_ready=0, out_valid=0, outputs 0. A fresh start with +1 (last) -> out_max_score=1, out_len=1.
- Saturation: SCORE_W=4, 10 beats of +1 with last on beat 10 -> acc and max saturate at 7; out_max_pos=7, out_len=10.
